// File: rtl/instr_loader.sv
// Loads a byte-serial program (length byte N, then 4*N bytes LSB first) into instruction memory.
// ins_write fires the cycle after each word's 4th byte; byte_ready drops during writes and outside a frame.
module instr_loader #(
   parameter int NUM_WORDS = 64,
   parameter int ADDR_W    = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              ins_write,
   output logic [31:0]       instruction_in,
   output logic [ADDR_W-1:0] ins_addr,
   output logic [ADDR_W:0]   word_count,
   output logic              cpu_hold,
   output logic              load_done
);

   typedef enum logic [2:0] {IDLE, LEN, COLLECT, WRITE, DONE} state_t;

   localparam logic [ADDR_W:0] NW = (ADDR_W+1)'(NUM_WORDS);

   state_t            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              ins_write_q, ins_write_d;
   logic [31:0]       instruction_in_q, instruction_in_d;
   logic [ADDR_W-1:0] ins_addr_q, ins_addr_d;
   logic [ADDR_W:0]   word_count_q, word_count_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              load_done_q, load_done_d;

   assign byte_ready     = (state_q == LEN) || (state_q == COLLECT);
   assign ins_write      = ins_write_q;
   assign instruction_in = instruction_in_q;
   assign ins_addr       = ins_addr_q;
   assign word_count     = word_count_q;
   assign cpu_hold       = cpu_hold_q;
   assign load_done      = load_done_q;

   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      len_d            = len_q;
      ins_write_d      = 1'b0;
      instruction_in_d = instruction_in_q;
      ins_addr_d       = ins_addr_q;
      word_count_d     = word_count_q;
      cpu_hold_d       = cpu_hold_q;
      load_done_d      = load_done_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = LEN;
               cpu_hold_d   = 1'b1;
               load_done_d  = 1'b0;
               word_count_d = '0;
               ins_addr_d   = '0;
            end
         end
         LEN: begin
            if (byte_valid) begin
               // Clamping N keeps ins_addr from wrapping within a frame.
               if (byte_data == 8'd0 || int'(byte_data) > NUM_WORDS)
                  len_d = NW;
               else
                  len_d = (ADDR_W+1)'(byte_data);
               idx_d   = 2'd0;
               state_d = COLLECT;
            end
         end
         COLLECT: begin
            if (byte_valid) begin
               instruction_in_d[8*idx_q +: 8] = byte_data;
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d     = WRITE;
                  ins_write_d = 1'b1;
               end
            end
         end
         WRITE: begin
            word_count_d = word_count_q + 1'b1;
            if (word_count_q + 1'b1 == len_q) begin
               state_d     = DONE;
               cpu_hold_d  = 1'b0;
               load_done_d = 1'b1;
            end else begin
               ins_addr_d = ins_addr_q + 1'b1;
               idx_d      = 2'd0;
               state_d    = COLLECT;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         idx_q            <= 2'd0;
         len_q            <= '0;
         ins_write_q      <= 1'b0;
         instruction_in_q <= '0;
         ins_addr_q       <= '0;
         word_count_q     <= '0;
         cpu_hold_q       <= 1'b1;
         load_done_q      <= 1'b0;
      end else begin
         state_q          <= state_d;
         idx_q            <= idx_d;
         len_q            <= len_d;
         ins_write_q      <= ins_write_d;
         instruction_in_q <= instruction_in_d;
         ins_addr_q       <= ins_addr_d;
         word_count_q     <= word_count_d;
         cpu_hold_q       <= cpu_hold_d;
         load_done_q      <= load_done_d;
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized frame stimulus checked cycle by cycle against a frame-level model and a write scoreboard.
module tb_instr_loader;
   localparam int NW = 64;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          byte_valid = 1'b0;
   logic [7:0]    byte_data = 8'h00;
   logic          byte_ready;
   logic          ins_write;
   logic [31:0]   instruction_in;
   logic [AW-1:0] ins_addr;
   logic [AW:0]   word_count;
   logic          cpu_hold;
   logic          load_done;

   instr_loader #(.NUM_WORDS(NW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(byte_ready), .ins_write(ins_write), .instruction_in(instruction_in),
      .ins_addr(ins_addr), .word_count(word_count), .cpu_hold(cpu_hold), .load_done(load_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clamp_len(input logic [7:0] b);
      if (b == 8'd0 || int'(b) > NW) return NW;
      return int'(b);
   endfunction

   // Frame-level model: bytes consumed so far, words written so far, flags.
   logic        m_valid = 1'b0;
   logic        m_busy, m_in_done, m_wr, m_hold, m_ld;
   int          m_nbytes, m_len, m_wc, m_addr;
   logic [31:0] m_data;

   function automatic logic exp_ready();
      return m_busy && !m_wr && !m_in_done && (m_nbytes == 0 || m_nbytes < 1 + 4 * m_len);
   endfunction

   typedef struct {int addr; logic [31:0] data;} wr_t;
   wr_t         exp_q[$];
   int          n_writes = 0;
   int          last_addr = -1;
   logic [31:0] last_data = '0;

   always @(negedge clk) begin
      logic xfer, new_wr;
      int   k;
      if (m_valid) begin
         chk("byte_ready", 32'(byte_ready), 32'(exp_ready()));
         chk("ins_write", 32'(ins_write), 32'(m_wr));
         chk("instruction_in", instruction_in, m_data);
         chk("ins_addr", 32'(ins_addr), 32'(m_addr));
         chk("word_count", 32'(word_count), 32'(m_wc));
         chk("cpu_hold", 32'(cpu_hold), 32'(m_hold));
         chk("load_done", 32'(load_done), 32'(m_ld));
         if (ins_write === 1'b1) begin
            n_writes++;
            last_addr = int'(ins_addr);
            last_data = instruction_in;
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 32'(1), 32'(0));
            end else begin
               chk("sb_data", instruction_in, exp_q[0].data);
               chk("sb_addr", 32'(ins_addr), 32'(exp_q[0].addr));
               void'(exp_q.pop_front());
            end
         end
      end
      if (rst) begin
         m_valid = 1'b1; m_busy = 1'b0; m_in_done = 1'b0; m_wr = 1'b0;
         m_hold = 1'b1; m_ld = 1'b0; m_nbytes = 0; m_len = 0; m_wc = 0; m_addr = 0;
         m_data = '0;
      end else if (m_valid) begin
         xfer   = byte_valid && exp_ready();
         new_wr = 1'b0;
         if (!m_busy && !m_in_done) begin
            if (start) begin
               m_busy = 1'b1; m_nbytes = 0; m_hold = 1'b1; m_ld = 1'b0; m_wc = 0; m_addr = 0;
            end
         end else if (m_in_done) begin
            m_in_done = 1'b0;
         end else begin
            if (m_wr) begin
               m_wc++;
               if (m_wc == m_len) begin
                  m_busy = 1'b0; m_in_done = 1'b1; m_hold = 1'b0; m_ld = 1'b1;
               end else begin
                  m_addr++;
               end
            end
            if (xfer) begin
               if (m_nbytes == 0) begin
                  m_len = clamp_len(byte_data);
               end else begin
                  k = (m_nbytes - 1) % 4;
                  m_data[8*k +: 8] = byte_data;
                  if (k == 3) new_wr = 1'b1;
               end
               m_nbytes++;
            end
         end
         m_wr = new_wr;
      end
   end

   logic [31:0] frame_words[$];

   task automatic cycle();
      @(posedge clk); #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; byte_valid = 1'b0;
      cycle();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_pct);
      logic taken = 1'b0;
      while ($urandom_range(99) < gap_pct) begin
         byte_valid = 1'b0; byte_data = 8'($urandom);
         cycle();
      end
      byte_valid = 1'b1; byte_data = b;
      for (int t = 0; t < 50 && !taken; t++) begin
         @(negedge clk); taken = byte_ready;
         cycle();
      end
      byte_valid = 1'b0;
      if (!taken) chk("byte_timeout", 32'(0), 32'(1));
   endtask

   task automatic wait_done();
      logic seen = 1'b0;
      for (int t = 0; t < 30 && !seen; t++) begin
         @(negedge clk); seen = load_done;
      end
      chk("done_timeout", 32'(seen), 32'(1));
      cycle();
   endtask

   task automatic run_frame(input logic [7:0] lb, input int gap_pct);
      int n = clamp_len(lb);
      for (int i = 0; i < n; i++) exp_q.push_back('{addr: i, data: frame_words[i]});
      pulse_start();
      send_byte(lb, gap_pct);
      for (int i = 0; i < n; i++)
         for (int k = 0; k < 4; k++) send_byte(frame_words[i][8*k +: 8], gap_pct);
      wait_done();
   endtask

   task automatic rand_words(input int n);
      frame_words.delete();
      for (int i = 0; i < n; i++) frame_words.push_back($urandom);
   endtask

   initial begin
      int w0;
      repeat (3) cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_byte_ready", 32'(byte_ready), 32'(0));
      chk("rst_cpu_hold", 32'(cpu_hold), 32'(1));
      chk("rst_word_count", 32'(word_count), 32'(0));
      cycle();

      // Single word, byte_valid held throughout.
      w0 = n_writes;
      frame_words = '{32'h00100133};
      run_frame(8'h01, 0);
      chk("single_writes", 32'(n_writes - w0), 32'(1));
      chk("single_data", last_data, 32'h00100133);
      chk("single_addr", 32'(last_addr), 32'(0));
      @(negedge clk);
      chk("single_done", 32'(load_done), 32'(1));
      chk("single_hold", 32'(cpu_hold), 32'(0));
      chk("single_wc", 32'(word_count), 32'(1));
      cycle();

      // Three words with random gaps.
      w0 = n_writes;
      frame_words = '{32'h11223344, 32'h55667788, 32'h9ABCDEF0};
      run_frame(8'h03, 40);
      chk("gap_writes", 32'(n_writes - w0), 32'(3));
      chk("gap_last_data", last_data, 32'h9ABCDEF0);
      chk("gap_last_addr", 32'(last_addr), 32'(2));

      // Length clamp, then excess bytes must not be consumed.
      w0 = n_writes;
      rand_words(NW);
      run_frame(8'hFF, 10);
      chk("clamp_writes", 32'(n_writes - w0), 32'(64));
      chk("clamp_last_addr", 32'(last_addr), 32'(63));
      byte_valid = 1'b1; byte_data = 8'hA5;
      repeat (4) begin
         @(negedge clk);
         chk("excess_ready", 32'(byte_ready), 32'(0));
         chk("clamp_wc", 32'(word_count), 32'(64));
         cycle();
      end
      byte_valid = 1'b0;

      // Zero length means a full memory load.
      w0 = n_writes;
      rand_words(NW);
      run_frame(8'h00, 5);
      chk("zero_writes", 32'(n_writes - w0), 32'(64));

      // Reset mid-COLLECT abandons the partial word.
      w0 = n_writes;
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'hDE, 0);
      send_byte(8'hAD, 0);
      rst = 1'b1; byte_valid = 1'b1; byte_data = 8'hBE;
      exp_q.delete();
      repeat (3) cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready", 32'(byte_ready), 32'(0));
      chk("mid_rst_write", 32'(ins_write), 32'(0));
      chk("mid_rst_hold", 32'(cpu_hold), 32'(1));
      chk("mid_rst_done", 32'(load_done), 32'(0));
      chk("mid_rst_wc", 32'(word_count), 32'(0));
      cycle();
      repeat (10) cycle();
      byte_valid = 1'b0;
      chk("mid_rst_no_write", 32'(n_writes - w0), 32'(0));

      // Restart: start mid-frame ignored, start from IDLE re-arms.
      frame_words = '{32'hCAFEF00D};
      run_frame(8'h01, 20);
      frame_words = '{32'h01020304, 32'hA1B2C3D4};
      for (int i = 0; i < 2; i++) exp_q.push_back('{addr: i, data: frame_words[i]});
      w0 = n_writes;
      pulse_start();
      send_byte(8'h02, 0);
      for (int k = 0; k < 4; k++) send_byte(frame_words[0][8*k +: 8], 0);
      for (int k = 0; k < 2; k++) send_byte(frame_words[1][8*k +: 8], 0);
      pulse_start();
      for (int k = 2; k < 4; k++) send_byte(frame_words[1][8*k +: 8], 0);
      wait_done();
      chk("restart_writes", 32'(n_writes - w0), 32'(2));
      chk("restart_last", last_data, 32'hA1B2C3D4);
      repeat (2) cycle();
      pulse_start();
      @(negedge clk);
      chk("rearm_hold", 32'(cpu_hold), 32'(1));
      chk("rearm_done", 32'(load_done), 32'(0));
      chk("rearm_wc", 32'(word_count), 32'(0));
      cycle();
      frame_words = '{32'h0BADBEEF};
      exp_q.push_back('{addr: 0, data: frame_words[0]});
      send_byte(8'h01, 30);
      for (int k = 0; k < 4; k++) send_byte(frame_words[0][8*k +: 8], 30);
      wait_done();
      chk("final_queue_empty", 32'(exp_q.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Drives the processor's instruction-write interface (`ins_write` / `instruction_in`) from a byte-serial program stream, e.g. a UART receiver or debug port.
- Frame format: one length byte N, then 4·N instruction bytes, least-significant byte first.
- Assembles each 32-bit word, pulses one write per word with an incrementing address, and holds the core in reset (`cpu_hold`) until the program is fully written.

Parameters:
- NUM_WORDS, 64, instruction memory depth in words; a length byte of 0 means NUM_WORDS.
- ADDR_W, 6, width of `ins_addr`; must satisfy 2^ADDR_W >= NUM_WORDS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a new load frame.
- byte_valid  input  1  `byte_data` is valid this cycle.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- ins_write  output  1  one-cycle instruction write strobe.
- instruction_in  output  32  assembled instruction word.
- ins_addr  output  ADDR_W  word address for the current write.
- word_count  output  ADDR_W+1  number of words written in the current or last frame.
- cpu_hold  output  1  reset request to the processor core.
- load_done  output  1  sticky flag: the last frame completed.

Behaviour:
- Reset values: state IDLE, byte_ready=0, ins_write=0, instruction_in=0, ins_addr=0, word_count=0, cpu_hold=1, load_done=0. Internal byte index and length register are cleared.
- Reset takes priority in every state. A reset mid-frame abandons the frame: no further ins_write, partial word discarded.
- A byte transfer occurs when byte_valid && byte_ready on a rising edge. Bytes with byte_ready=0 are not consumed; the source must hold them.
- States:
  - IDLE: byte_ready=0. start → LEN, and in the same edge set cpu_hold=1, load_done=0, word_count=0, ins_addr=0.
  - LEN: byte_ready=1. On transfer, latch N = (byte_data==0 ? NUM_WORDS : min(byte_data, NUM_WORDS)) → COLLECT, byte index=0.
  - COLLECT: byte_ready=1. On transfer, write byte_data into instruction_in[8·idx +: 8] and increment idx. On the 4th byte (idx==3) → WRITE.
  - WRITE: byte_ready=0. ins_write=1 for exactly this cycle; instruction_in and ins_addr are stable. Next edge: word_count+1. If word_count+1==N → DONE; else ins_addr+1, idx=0 → COLLECT.
  - DONE: byte_ready=0. cpu_hold=0 and load_done=1 from the DONE cycle onward → IDLE on the next edge.
- Length bytes greater than NUM_WORDS are clamped to NUM_WORDS. Excess stream bytes are never accepted: byte_ready=0 in IDLE.
- Latency: the ins_write cycle is the cycle after the 4th byte transfer. Minimum frame time: 1 + 5·N cycles plus DONE.
- instruction_in holds its last value outside WRITE. Bytes of the next word overwrite lanes in place.
- start is ignored in LEN, COLLECT, WRITE and DONE. A new frame may begin only from IDLE.
- ins_addr never wraps within a frame because of the N clamp. word_count saturates at NUM_WORDS.
- Outputs are registered except byte_ready, which is decoded from state.

Test Plan:
- Reset: hold rst 3 cycles mid-COLLECT → next cycle byte_ready=0, ins_write=0, cpu_hold=1, load_done=0, word_count=0, and no write ever occurs for the partial word.
- Single word: start, then bytes 0x01, 0x33, 0x01, 0x10, 0x00 with byte_valid held → one ins_write pulse with instruction_in=0x00100133, ins_addr=0, then load_done=1, cpu_hold=0, word_count=1.
- Backpressure and gaps: N=3, random byte_valid gaps, 0x11223344/0x55667788/0x9ABCDEF0 sent LSB first → exactly 3 pulses at addresses 0, 1, 2 with those words; byte_ready=0 in every ins_write cycle and no byte is lost.
- Clamp: length byte 0xFF with NUM_WORDS=64 → exactly 64 writes, last ins_addr=63, word_count=64, then byte_ready=0 and further bytes are not consumed.
- Zero length: length byte 0x00 → 64 writes (NUM_WORDS), then load_done=1.
- Restart: complete a frame, pulse start mid-COLLECT of a second frame (ignored), finish it, pulse start from IDLE → cpu_hold returns to 1, load_done=0, word_count=0 the cycle after that start.
